// File: rtl/bus_sram_slave_if.sv
// Start/done memory bus between a core-side master and an SRAM slave.
// The berr wire exists only when BUS_SRAM_SLAVE_MISALIGN_ERR_EN is defined.
interface bus_sram_slave_if;
    logic        breq;
    logic        bstart;
    logic        ttype;    // 0 = READ, 1 = WRITE
    logic [1:0]  tsize;    // 00 BYTE, 01 HALF, 1x WORD
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        bdone;
`ifdef BUS_SRAM_SLAVE_MISALIGN_ERR_EN
    logic        berr;

    modport master (output breq, bstart, ttype, tsize, addr, wdata,
                    input  rdata, bdone, berr);
    modport slave  (input  breq, bstart, ttype, tsize, addr, wdata,
                    output rdata, bdone, berr);
`else
    modport master (output breq, bstart, ttype, tsize, addr, wdata,
                    input  rdata, bdone);
    modport slave  (input  breq, bstart, ttype, tsize, addr, wdata,
                    output rdata, bdone);
`endif
endinterface

// File: rtl/bus_sram_slave.sv
// Word-wide single-port SRAM slave with byte/half/word lanes and programmable wait states.
// Optional BUS_SRAM_SLAVE_MISALIGN_ERR_EN: misaligned accesses are rejected with berr instead of masked.
module bus_sram_slave #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0,
    parameter     INIT_FILE   = ""
) (
    input logic            clk,
    input logic            rst_n,
    bus_sram_slave_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_e;

    state_e state, state_nxt;
    logic   accept;

    logic [AW-1:0] idx_q;
    logic [1:0]    lane_q;
    logic          wr_q;
    logic [1:0]    size_q;
    logic [31:0]   wdata_q;
    logic [3:0]    cnt_q;
    logic [31:0]   rdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    // Upper address bits are decoded by the crossbar; accesses wrap in the array.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[31:AW+2];

    logic is_byte, is_half, mis;
    assign is_byte = (size_q == 2'b00);
    assign is_half = (size_q == 2'b01);
`ifdef BUS_SRAM_SLAVE_MISALIGN_ERR_EN
    assign mis = (is_half && lane_q[0]) || (!is_byte && !is_half && (lane_q != 2'b00));
`else
    assign mis = 1'b0;
`endif

    // Lane enables implicitly mask misaligned low bits for HALF/WORD.
    logic [3:0]  be;
    logic [31:0] wlane;
    always_comb begin
        be    = 4'b1111;
        wlane = wdata_q;
        if (is_byte) begin
            be    = 4'b0001 << lane_q;
            wlane = {4{wdata_q[7:0]}};
        end else if (is_half) begin
            be    = lane_q[1] ? 4'b1100 : 4'b0011;
            wlane = {2{wdata_q[15:0]}};
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_IDLE: if (bus.bstart && bus.breq) begin
                accept    = 1'b1;
                state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
            end
            S_WAIT:   if (cnt_q == 4'd0) state_nxt = S_ACCESS;
            S_ACCESS: state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    logic [31:0] word_rd, rd_ext;
    assign word_rd = mem[idx_q];
    always_comb begin
        rd_ext = word_rd;
        if (is_byte)      rd_ext = {24'b0, 8'(word_rd >> {lane_q, 3'b000})};
        else if (is_half) rd_ext = {16'b0, lane_q[1] ? word_rd[31:16] : word_rd[15:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                idx_q   <= bus.addr[AW+1:2];
                lane_q  <= bus.addr[1:0];
                wr_q    <= bus.ttype;
                size_q  <= bus.tsize;
                wdata_q <= bus.wdata;
                cnt_q   <= 4'(WAIT_STATES - 1);
            end else if (state == S_WAIT && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (state == S_ACCESS && !wr_q && !mis)
                rdata_q <= rd_ext;
        end
    end

    // Array has no reset; reset forces IDLE so an abandoned write never lands.
    always_ff @(posedge clk) begin
        if (state == S_ACCESS && wr_q && !mis) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx_q][8*i +: 8] <= wlane[8*i +: 8];
        end
    end

    assign bus.bdone = (state == S_DONE);
    assign bus.rdata = rdata_q;
`ifdef BUS_SRAM_SLAVE_MISALIGN_ERR_EN
    assign bus.berr  = (state == S_DONE) && mis;
`endif
endmodule

// File: tb/tb_bus_sram_slave.sv
// Directed bench for bus_sram_slave: one instance with no wait states, one with three.
module tb_bus_sram_slave;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bus_sram_slave_if if0 ();
    bus_sram_slave_if if1 ();

    bus_sram_slave #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    bus_sram_slave #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input int d, input logic bs, input logic br, input logic wr,
                         input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        if (d == 0) begin
            if0.bstart = bs; if0.breq = br; if0.ttype = wr; if0.tsize = sz; if0.addr = a; if0.wdata = wd;
        end else begin
            if1.bstart = bs; if1.breq = br; if1.ttype = wr; if1.tsize = sz; if1.addr = a; if1.wdata = wd;
        end
    endtask

    function automatic logic get_bdone(input int d);
        return (d == 0) ? if0.bdone : if1.bdone;
    endfunction

    function automatic logic [31:0] get_rdata(input int d);
        return (d == 0) ? if0.rdata : if1.rdata;
    endfunction

    function automatic logic get_berr(input int d);
`ifdef BUS_SRAM_SLAVE_MISALIGN_ERR_EN
        return (d == 0) ? if0.berr : if1.berr;
`else
        return 1'b0;
`endif
    endfunction

    // One transfer; inputs are scrambled right after accept to prove they were latched.
    task automatic xfer(input int d, input logic wr, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output int lat, output logic er);
        @(posedge clk); #1;
        drive(d, 1'b1, 1'b1, wr, sz, a, wd);
        lat = 0;
        do begin
            @(posedge clk); #1;
            if (lat == 0) drive(d, 1'b1, 1'b1, ~wr, ~sz, ~a, ~wd);
            lat++;
        end while (!get_bdone(d) && lat < 50);
        chk("bdone_seen", {31'b0, get_bdone(d)}, 32'd1);
        rd = get_rdata(d);
        er = get_berr(d);
        drive(d, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    logic [31:0] rd;
    int          lat;
    logic        er;
    int          cnt;

    initial begin
        drive(0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bdone0", {31'b0, if0.bdone}, 32'd0);
        chk("rst_rdata0", if0.rdata, 32'h0);
        chk("rst_bdone1", {31'b0, if1.bdone}, 32'd0);
        rst_n = 1'b1;

        // 1: word write then read, zero wait states
        xfer(0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, rd, lat, er);
        chk("t1_wr_lat", 32'(lat), 32'd2);
        chk("t1_wr_rdata_hold", rd, 32'h0);
        xfer(0, 1'b0, 2'b10, 32'h10, 32'h0, rd, lat, er);
        chk("t1_rd_lat", 32'(lat), 32'd2);
        chk("t1_rd_data", rd, 32'hDEADBEEF);
        chk("t1_berr", {31'b0, er}, 32'd0);

        // 2: byte write and sub-word reads
        xfer(0, 1'b1, 2'b00, 32'h11, 32'hFFFF_FFA5, rd, lat, er);
        chk("t2_wr_rdata_hold", rd, 32'hDEADBEEF);
        xfer(0, 1'b0, 2'b10, 32'h10, 32'h0, rd, lat, er);
        chk("t2_rd_word", rd, 32'hDEADA5EF);
        xfer(0, 1'b0, 2'b00, 32'h13, 32'h0, rd, lat, er);
        chk("t2_rd_byte3", rd, 32'h000000DE);
        xfer(0, 1'b0, 2'b01, 32'h12, 32'h0, rd, lat, er);
        chk("t2_rd_half_hi", rd, 32'h0000DEAD);
        xfer(0, 1'b0, 2'b00, 32'h10, 32'h0, rd, lat, er);
        chk("t2_rd_byte0", rd, 32'h000000EF);
        xfer(0, 1'b1, 2'b10, 32'h14, 32'h0, rd, lat, er);
        xfer(0, 1'b1, 2'b01, 32'h16, 32'h5555_1234, rd, lat, er);
        xfer(0, 1'b0, 2'b10, 32'h14, 32'h0, rd, lat, er);
        chk("t2_half_wr_hi", rd, 32'h12340000);

        // 3: three wait states, bstart held through DONE
        xfer(1, 1'b1, 2'b10, 32'h20, 32'hCAFEF00D, rd, lat, er);
        chk("t3_wr_lat", 32'(lat), 32'd5);
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b1, 1'b0, 2'b10, 32'h20, 32'h0);
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!if1.bdone && lat < 50);
        chk("t3_rd_lat", 32'(lat), 32'd5);
        chk("t3_rd_data", if1.rdata, 32'hCAFEF00D);
        @(posedge clk); #1;
        chk("t3_bdone_width", {31'b0, if1.bdone}, 32'd0);
        drive(1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        cnt = 0;
        repeat (8) begin @(posedge clk); #1; if (if1.bdone) cnt++; end
        chk("t3_no_reaccept", 32'(cnt), 32'd0);

        // 4: reset during WAIT of a write
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b1, 1'b1, 2'b10, 32'h20, 32'h12345678);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t4_rst_bdone", {31'b0, if1.bdone}, 32'd0);
        chk("t4_rst_rdata", if1.rdata, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk("t4_rst_bdone_hold", {31'b0, if1.bdone}, 32'd0);
        rst_n = 1'b1;
        xfer(1, 1'b0, 2'b10, 32'h20, 32'h0, rd, lat, er);
        chk("t4_rd_lat", 32'(lat), 32'd5);
        chk("t4_old_data", rd, 32'hCAFEF00D);

        // 5: address wrap, and bstart without breq
        xfer(0, 1'b1, 2'b10, 32'h1000_0004, 32'h0BADF00D, rd, lat, er);
        xfer(0, 1'b0, 2'b10, 32'h4, 32'h0, rd, lat, er);
        chk("t5_wrap", rd, 32'h0BADF00D);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 1'b0, 2'b10, 32'h4, 32'h0);
        cnt = 0;
        repeat (6) begin @(posedge clk); #1; if (if0.bdone) cnt++; end
        chk("t5_no_breq", 32'(cnt), 32'd0);
        drive(0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);

        // 6: misaligned half write
        xfer(0, 1'b1, 2'b10, 32'h20, 32'h11223344, rd, lat, er);
        xfer(0, 1'b1, 2'b01, 32'h21, 32'h0000BEEF, rd, lat, er);
`ifdef BUS_SRAM_SLAVE_MISALIGN_ERR_EN
        chk("t6_berr", {31'b0, er}, 32'd1);
        xfer(0, 1'b0, 2'b10, 32'h20, 32'h0, rd, lat, er);
        chk("t6_unchanged", rd, 32'h11223344);
        chk("t6_berr_clear", {31'b0, er}, 32'd0);
`else
        chk("t6_berr", {31'b0, er}, 32'd0);
        xfer(0, 1'b0, 2'b10, 32'h20, 32'h0, rd, lat, er);
        chk("t6_masked_wr", rd, 32'h1122BEEF);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
